// File: rtl/axi_pkg.sv
// AXI4 shared types and helpers for the read burst sequencer.
// Holds AXI enums, the host read command record, 4 KB boundary math and response merging.
package axi_pkg;

  typedef enum logic [2:0] {
    AXI_SIZE_1B   = 3'd0,
    AXI_SIZE_2B   = 3'd1,
    AXI_SIZE_4B   = 3'd2,
    AXI_SIZE_8B   = 3'd3,
    AXI_SIZE_16B  = 3'd4,
    AXI_SIZE_32B  = 3'd5,
    AXI_SIZE_64B  = 3'd6,
    AXI_SIZE_128B = 3'd7
  } AxiSize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2,
    AXI_BURST_RSVD  = 2'd3
  } AxiBurst_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } AxiResp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [15:0] bytes;
    AxiBurst_t   burst;
  } AxiHostRdCtrl_t;

  localparam int unsigned AXI_4K_BOUNDARY = 4096;

  // Beats of the given size that fit between addr and the next 4 KB page edge.
  function automatic logic [12:0] axiBeatsTo4k(input logic [11:0] addr, input AxiSize_t size);
    logic [12:0] room;
    room = 13'(AXI_4K_BOUNDARY) - {1'b0, addr};
    return room >> size;
  endfunction

  // EXOKAY is treated as OKAY so the numeric max ranks DECERR > SLVERR > OKAY.
  function automatic AxiResp_t axiRespMerge(input AxiResp_t a, input AxiResp_t b);
    AxiResp_t na;
    AxiResp_t nb;
    na = (a == AXI_RESP_EXOKAY) ? AXI_RESP_OKAY : a;
    nb = (b == AXI_RESP_EXOKAY) ? AXI_RESP_OKAY : b;
    return (nb > na) ? nb : na;
  endfunction

endpackage

// File: rtl/axi_rd_burst_ctrl_calc.sv
// Burst length / next-address calculator for axi_rd_burst_ctrl.
// Purely combinational; the parent registers the results during its CALC cycle.
module axi_rd_burst_calc
  import axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_LEN = 256
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [16:0]       beats_left_i,
  output logic [8:0]        len_o,
  output logic [ADDR_W-1:0] addr_next_o,
  output logic [16:0]       beats_next_o
);

  localparam int SIZE = $clog2(DATA_W / 8);

  logic [16:0] room;
  logic [16:0] lim;

  // Clamp by remaining beats, the protocol burst limit and the 4 KB page edge.
  always_comb begin
    room = 17'(axiBeatsTo4k(addr_i[11:0], AxiSize_t'(3'(SIZE))));
    lim  = beats_left_i;
    if (lim > 17'(MAX_LEN)) lim = 17'(MAX_LEN);
    if (lim > room) lim = room;
    len_o = 9'(lim);
  end

  assign addr_next_o  = addr_i + (ADDR_W'(len_o) << SIZE);
  assign beats_next_o = beats_left_i - 17'(len_o);

endmodule

// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read-master sequencer: splits one host read into legal INCR bursts and streams R to AXI-Stream.
// Optional AXI_RD_ERR_ABORT_EN: stop issuing bursts after the first error beat, draining the current one.
module axi_rd_burst_ctrl
  import axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  input  logic [ADDR_W-1:0] ctrl_address,
  input  logic [15:0]       ctrl_bytes,
  input  logic [1:0]        ctrl_burst,
  output logic              sts_valid,
  output logic [1:0]        sts_resp,
  output logic              busy,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  localparam int BB   = DATA_W / 8;
  localparam int SIZE = $clog2(BB);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_AR   = 3'd2;
  localparam logic [2:0] ST_R    = 3'd3;
  localparam logic [2:0] ST_STS  = 3'd4;

  logic [2:0]        state_q, state_d;
  AxiResp_t          resp_q, resp_d;
  logic [ADDR_W-1:0] addr_q, addr_next_q, calc_addr_next;
  logic [16:0]       beats_left_q, beats_next_q, calc_beats_next;
  logic [8:0]        len_q, beat_cnt_q, calc_len;
  logic              skip_q;
  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;
  logic              arvalid_q;

  logic              cmd_bad;
  logic [16:0]       cmd_beats;
  logic              r_fire;
  logic              last_of_burst;
  logic              final_burst;
  AxiResp_t          beat_merged;
  logic              abort_now;

  axi_rd_burst_calc #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN)
  ) u_calc (
    .addr_i      (addr_q),
    .beats_left_i(beats_left_q),
    .len_o       (calc_len),
    .addr_next_o (calc_addr_next),
    .beats_next_o(calc_beats_next)
  );

  assign cmd_bad   = (ctrl_burst != 2'(AXI_BURST_INCR)) ||
                     ((ctrl_address & ADDR_W'(BB - 1)) != '0);
  assign cmd_beats = (17'(ctrl_bytes) + 17'(BB - 1)) >> SIZE;

  assign r_fire        = (state_q == ST_R) && m_axi_rvalid && m_axis_tready;
  assign last_of_burst = (beat_cnt_q + 9'd1) == len_q;
  assign final_burst   = (beats_next_q == '0);

  // A beat whose rlast disagrees with our own count is reported as SLVERR.
  always_comb begin
    beat_merged = axiRespMerge(resp_q, AxiResp_t'(m_axi_rresp));
    if (m_axi_rlast != last_of_burst) beat_merged = axiRespMerge(beat_merged, AXI_RESP_SLVERR);
  end

`ifdef AXI_RD_ERR_ABORT_EN
  assign abort_now = (beat_merged >= AXI_RESP_SLVERR);
`else
  assign abort_now = 1'b0;
`endif

  assign ctrl_ready    = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_CALC) || (state_q == ST_AR) || (state_q == ST_R);
  assign sts_valid     = (state_q == ST_STS);
  assign sts_resp      = resp_q;
  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arburst = arburst_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == ST_R) && m_axis_tready;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tvalid = (state_q == ST_R) && m_axi_rvalid;
  assign m_axis_tlast  = (state_q == ST_R) && last_of_burst && (final_burst || abort_now);

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_valid) begin
          state_d = ST_CALC;
          resp_d  = ((ctrl_bytes != '0) && cmd_bad) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
      end
      ST_CALC: state_d = (skip_q || (beats_left_q == '0)) ? ST_STS : ST_AR;
      ST_AR:   if (m_axi_arready) state_d = ST_R;
      ST_R: begin
        if (r_fire) begin
          resp_d = beat_merged;
          if (last_of_burst) state_d = (final_burst || abort_now) ? ST_STS : ST_CALC;
        end
      end
      ST_STS:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers follow the FSM; AR fields stay frozen from CALC until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_q       <= AXI_RESP_OKAY;
      addr_q       <= '0;
      addr_next_q  <= '0;
      beats_left_q <= '0;
      beats_next_q <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      skip_q       <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arvalid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_valid) begin
            addr_q       <= ctrl_address;
            beats_left_q <= cmd_beats;
            skip_q       <= cmd_bad;
          end
        end
        ST_CALC: begin
          if (state_d == ST_AR) begin
            len_q        <= calc_len;
            addr_next_q  <= calc_addr_next;
            beats_next_q <= calc_beats_next;
            beat_cnt_q   <= '0;
            araddr_q     <= addr_q;
            arlen_q      <= 8'(calc_len - 9'd1);
            arsize_q     <= 3'(SIZE);
            arburst_q    <= 2'(AXI_BURST_INCR);
            arvalid_q    <= 1'b1;
          end
        end
        ST_AR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            arid_q    <= arid_q + ID_W'(1);
          end
        end
        ST_R: begin
          if (r_fire) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            if (last_of_burst) begin
              addr_q       <= addr_next_q;
              beats_left_q <= beats_next_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
